// File: rtl/attack_scheduler.sv
// Cracking-run sequencer: streams dictionary words from BRAM, then brute-force counters,
// to the hash engine one at a time and compares each returned hash against the captured target.
module attack_scheduler #(
   parameter int unsigned DICT_START     = 1,
   parameter int unsigned DICT_SIZE      = 10,
   parameter int unsigned BRUTE_ATTEMPTS = 100,
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned WORD_W         = 11,
   parameter int unsigned HASH_W         = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [HASH_W-1:0] target_hash,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              cand_valid,
   output logic [WORD_W-1:0] cand_data,
   input  logic              cand_ready,
   input  logic              hash_valid,
   input  logic [HASH_W-1:0] hash_data,
   output logic [2:0]        state,
   output logic [WORD_W-1:0] found_word,
   output logic [31:0]       attempts
);

   typedef enum logic [3:0] {
      StIdle,
      StDictRd,
      StDictLat,
      StDictSend,
      StDictHash,
      StBruteSend,
      StBruteHash,
      StDoneOk,
      StDoneFail
   } fsm_e;

   localparam logic [2:0] OutWait  = 3'd0;
   localparam logic [2:0] OutDict  = 3'd1;
   localparam logic [2:0] OutBrute = 3'd2;
   localparam logic [2:0] OutOk    = 3'd3;
   localparam logic [2:0] OutFail  = 3'd4;

   localparam logic [31:0] DictLast  = (DICT_SIZE == 0) ? 32'd0 : 32'(DICT_SIZE - 1);
   localparam logic [31:0] BruteLast = (BRUTE_ATTEMPTS == 0) ? 32'd0 : 32'(BRUTE_ATTEMPTS - 1);

   fsm_e              fsm_q;
   logic [HASH_W-1:0] target_q;
   logic [31:0]       dict_idx_q;
   logic [31:0]       brute_cnt_q;

   logic              hash_hit;
   logic [31:0]       attempts_inc;

   assign hash_hit     = (hash_data == target_q);
   assign attempts_inc = (attempts == '1) ? attempts : attempts + 32'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q       <= StIdle;
         target_q    <= '0;
         dict_idx_q  <= '0;
         brute_cnt_q <= '0;
         state       <= OutWait;
         mem_en      <= 1'b0;
         mem_addr    <= '0;
         cand_valid  <= 1'b0;
         cand_data   <= '0;
         found_word  <= '0;
         attempts    <= '0;
      end else begin
         unique case (fsm_q)
            StIdle: begin
               if (start) begin
                  target_q <= target_hash;
                  if (DICT_SIZE > 0) begin
                     fsm_q      <= StDictRd;
                     state      <= OutDict;
                     dict_idx_q <= '0;
                     mem_en     <= 1'b1;
                     mem_addr   <= ADDR_W'(DICT_START);
                  end else begin
                     fsm_q       <= StBruteSend;
                     state       <= OutBrute;
                     brute_cnt_q <= '0;
                     cand_data   <= '0;
                     cand_valid  <= 1'b1;
                  end
               end
            end

            StDictRd: begin
               mem_en <= 1'b0;
               fsm_q  <= StDictLat;
            end

            // BRAM data is valid during this cycle (one cycle after the read strobe).
            StDictLat: begin
               cand_data  <= mem_rdata;
               cand_valid <= 1'b1;
               fsm_q      <= StDictSend;
            end

            StDictSend: begin
               if (cand_ready) begin
                  cand_valid <= 1'b0;
                  fsm_q      <= StDictHash;
               end
            end

            StDictHash: begin
               if (hash_valid) begin
                  attempts <= attempts_inc;
                  if (hash_hit) begin
                     found_word <= cand_data;
                     fsm_q      <= StDoneOk;
                     state      <= OutOk;
                  end else if (dict_idx_q == DictLast) begin
                     fsm_q       <= StBruteSend;
                     state       <= OutBrute;
                     brute_cnt_q <= '0;
                     cand_data   <= '0;
                     cand_valid  <= 1'b1;
                  end else begin
                     dict_idx_q <= dict_idx_q + 32'd1;
                     mem_en     <= 1'b1;
                     mem_addr   <= ADDR_W'(DICT_START + dict_idx_q + 32'd1);
                     fsm_q      <= StDictRd;
                  end
               end
            end

            StBruteSend: begin
               if (cand_ready) begin
                  cand_valid <= 1'b0;
                  fsm_q      <= StBruteHash;
               end
            end

            StBruteHash: begin
               if (hash_valid) begin
                  attempts <= attempts_inc;
                  if (hash_hit) begin
                     found_word <= cand_data;
                     fsm_q      <= StDoneOk;
                     state      <= OutOk;
                  end else if (brute_cnt_q == BruteLast) begin
                     fsm_q <= StDoneFail;
                     state <= OutFail;
                  end else begin
                     brute_cnt_q <= brute_cnt_q + 32'd1;
                     cand_data   <= WORD_W'(brute_cnt_q + 32'd1);
                     cand_valid  <= 1'b1;
                     fsm_q       <= StBruteSend;
                  end
               end
            end

            // Terminal states are sticky until reset.
            StDoneOk: begin
               state <= OutOk;
            end

            StDoneFail: begin
               state <= OutFail;
            end

            default: begin
               fsm_q      <= StIdle;
               state      <= OutWait;
               mem_en     <= 1'b0;
               cand_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_attack_scheduler.sv
// Scoreboard bench for attack_scheduler: BRAM and hash-engine models, queued expected reads and
// candidates checked by a monitor, plus a DICT_SIZE=0 instance.
module tb_attack_scheduler;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         start;
   logic [127:0] target_hash;
   logic         mem_en;
   logic [7:0]   mem_addr;
   logic [10:0]  mem_rdata = '0;
   logic         cand_valid;
   logic [10:0]  cand_data;
   logic         cand_ready;
   logic         hash_valid;
   logic [127:0] hash_data;
   logic [2:0]   state;
   logic [10:0]  found_word;
   logic [31:0]  attempts;

   logic         start0;
   logic [127:0] target_hash0;
   logic         mem_en0;
   logic [7:0]   mem_addr0;
   logic [10:0]  mem_rdata0 = '0;
   logic         cand_valid0;
   logic [10:0]  cand_data0;
   logic         cand_ready0 = 1'b1;
   logic         hash_valid0;
   logic [127:0] hash_data0;
   logic [2:0]   state0;
   logic [10:0]  found_word0;
   logic [31:0]  attempts0;

   attack_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .target_hash(target_hash),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cand_valid(cand_valid), .cand_data(cand_data), .cand_ready(cand_ready),
      .hash_valid(hash_valid), .hash_data(hash_data),
      .state(state), .found_word(found_word), .attempts(attempts)
   );

   attack_scheduler #(.DICT_SIZE(0), .BRUTE_ATTEMPTS(3)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .target_hash(target_hash0),
      .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
      .cand_valid(cand_valid0), .cand_data(cand_data0), .cand_ready(cand_ready0),
      .hash_valid(hash_valid0), .hash_data(hash_data0),
      .state(state0), .found_word(found_word0), .attempts(attempts0)
   );

   int checks = 0;
   int failures = 0;

   logic [10:0] mem [256];
   logic [7:0]  exp_addr[$];
   logic [10:0] exp_cand[$];

   int           stall_len = 0;
   int           stall_cycles = 0;
   int           acc_count = 0;
   logic [10:0]  acc_word = '0;
   int           stray_cnt = 0;
   logic [127:0] stray_hash = '0;
   int           mem0_reads = 0;
   logic         saw_dict0 = 1'b0;

   function automatic logic [127:0] hfun(input logic [10:0] w);
      hfun = {64'hC0FFEE0012345678, 53'd0, w};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem[mem_addr];
   end

   // Monitor runs just after each edge; cand_ready only moves on negedges so it still holds
   // the value the DUT sampled.
   logic        prev_v = 1'b0;
   logic [10:0] prev_d = '0;
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (prev_v && cand_ready) begin
            acc_word = prev_d;
            acc_count++;
            if (exp_cand.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra candidate: got %0h expected none", prev_d);
            end else begin
               chk("candidate", prev_d, exp_cand.pop_front());
            end
         end else if (prev_v) begin
            stall_cycles++;
            chk("cand_valid held", cand_valid, 1);
            chk("cand_data stable", cand_data, prev_d);
         end
         if (mem_en) begin
            if (exp_addr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra read: got addr %0d expected none", mem_addr);
            end else begin
               chk("read addr", mem_addr, exp_addr.pop_front());
            end
         end
      end
      if (mem_en0) mem0_reads++;
      if (state0 == 3'd1) saw_dict0 = 1'b1;
      prev_v = cand_valid;
      prev_d = cand_data;
   end

   // Hash engine model: result two edges after acceptance, optional ready stall per candidate.
   initial begin
      int pend;
      int vcnt;
      int acc_seen;
      int stray_seen;
      logic [10:0] w;
      pend = 0; vcnt = 0; acc_seen = 0; stray_seen = 0; w = '0;
      cand_ready = 1'b1; hash_valid = 1'b0; hash_data = '0;
      forever begin
         @(negedge clk);
         hash_valid = 1'b0;
         if (pend == 1) begin
            hash_valid = 1'b1;
            hash_data  = hfun(w);
            pend       = 0;
         end
         if (acc_count != acc_seen) begin
            acc_seen = acc_count;
            w        = acc_word;
            pend     = 1;
         end
         if (stray_cnt != stray_seen) begin
            stray_seen = stray_cnt;
            hash_valid = 1'b1;
            hash_data  = stray_hash;
         end
         if (cand_valid) begin
            if (vcnt < stall_len) begin
               cand_ready = 1'b0;
               vcnt++;
            end else begin
               cand_ready = 1'b1;
            end
         end else begin
            vcnt = 0;
            cand_ready = 1'b1;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_addr.delete();
      exp_cand.delete();
   endtask

   task automatic do_start(input logic [127:0] t);
      @(negedge clk);
      start = 1'b1;
      target_hash = t;
      @(negedge clk);
      start = 1'b0;
      target_hash = ~t;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (state != 3'd3 && state != 3'd4 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("run ends in budget", (state == 3'd3 || state == 3'd4), 1);
   endtask

   task automatic wait_attempts(input int a, input int maxc);
      int n = 0;
      while (attempts != 32'(a) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("attempts reached", attempts, a);
   endtask

   task automatic push_dict(input int k);
      for (int i = 1; i <= k; i++) begin
         exp_addr.push_back(8'(i));
         exp_cand.push_back(mem[i]);
      end
   endtask

   task automatic push_brute(input int k);
      for (int i = 0; i < k; i++) exp_cand.push_back(11'(i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      for (int a = 0; a < 256; a++) mem[a] = 11'(256 + 3 * a);
      reset = 1'b1; start = 1'b0; target_hash = '0;
      start0 = 1'b0; target_hash0 = '0; hash_valid0 = 1'b0; hash_data0 = '0;
      repeat (3) @(negedge clk);
      chk("rst state", state, 0);
      chk("rst mem_en", mem_en, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst cand_valid", cand_valid, 0);
      chk("rst cand_data", cand_data, 0);
      chk("rst found_word", found_word, 0);
      chk("rst attempts", attempts, 0);
      chk("rst state0", state0, 0);
      reset = 1'b0;

      // Dictionary hit on the fourth word.
      push_dict(4);
      do_start(hfun(mem[4]));
      chk("t1 state after start", state, 1);
      chk("t1 mem_en after start", mem_en, 1);
      @(negedge clk);
      chk("t1 mem_en drops", mem_en, 0);
      chk("t1 no early cand", cand_valid, 0);
      @(negedge clk);
      chk("t1 cand_valid latency", cand_valid, 1);
      chk("t1 first cand", cand_data, mem[1]);
      wait_done(200);
      chk("t1 state", state, 3);
      chk("t1 found_word", found_word, mem[4]);
      chk("t1 attempts", attempts, 4);
      chk("t1 reads left", exp_addr.size(), 0);
      chk("t1 cands left", exp_cand.size(), 0);

      // Brute value 7 matches after the dictionary is exhausted.
      do_reset();
      push_dict(10);
      push_brute(8);
      do_start(hfun(11'd7));
      wait_attempts(9, 200);
      chk("t2 still dict", state, 1);
      wait_attempts(10, 50);
      chk("t2 brute phase", state, 2);
      wait_done(200);
      chk("t2 state", state, 3);
      chk("t2 found_word", found_word, 7);
      chk("t2 attempts", attempts, 18);
      chk("t2 cands left", exp_cand.size(), 0);

      // No match anywhere.
      do_reset();
      push_dict(10);
      push_brute(100);
      do_start(128'h1);
      wait_done(2000);
      chk("t3 state", state, 4);
      chk("t3 attempts", attempts, 110);
      chk("t3 last cand", cand_data, 99);
      repeat (10) @(negedge clk);
      chk("t3 no more valid", cand_valid, 0);
      chk("t3 sticky", state, 4);
      chk("t3 cands left", exp_cand.size(), 0);

      // Ready stalled 5 cycles; start mid-run ignored.
      do_reset();
      stall_len = 5;
      stall_cycles = 0;
      push_dict(1);
      do_start(hfun(mem[1]));
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t4 state unchanged", state, 1);
      chk("t4 still offering", cand_valid, 1);
      wait_done(200);
      stall_len = 0;
      chk("t4 stall cycles", stall_cycles, 5);
      chk("t4 state", state, 3);
      chk("t4 found_word", found_word, mem[1]);
      chk("t4 attempts", attempts, 1);
      chk("t4 reads left", exp_addr.size(), 0);

      // Reset while a brute hash is outstanding, then stray hashes.
      do_reset();
      push_dict(10);
      push_brute(100);
      do_start(128'h2);
      wait_attempts(10, 200);
      n = 0;
      while (cand_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5 in brute hash", state, 2);
      reset = 1'b1;
      #1;
      chk("t5 async state", state, 0);
      chk("t5 async attempts", attempts, 0);
      chk("t5 async cand_valid", cand_valid, 0);
      chk("t5 async cand_data", cand_data, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_addr.delete();
      exp_cand.delete();
      stray_hash = 128'h2;
      stray_cnt++;
      repeat (5) @(negedge clk);
      chk("t5 stray state", state, 0);
      chk("t5 stray attempts", attempts, 0);
      chk("t5 stray found", found_word, 0);
      push_dict(2);
      do_start(hfun(mem[2]));
      chk("t5 restart addr", mem_addr, 1);
      wait_done(200);
      chk("t5 state", state, 3);
      chk("t5 found_word", found_word, mem[2]);
      chk("t5 attempts", attempts, 2);

      // DICT_SIZE=0 instance goes straight to brute.
      @(negedge clk);
      start0 = 1'b1;
      target_hash0 = hfun(11'd1);
      @(negedge clk);
      start0 = 1'b0;
      target_hash0 = '0;
      chk("t6 state direct", state0, 2);
      for (int i = 0; i < 2; i++) begin
         n = 0;
         while (!cand_valid0 && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("t6 cand_valid", cand_valid0, 1);
         chk("t6 cand_data", cand_data0, i);
         @(negedge clk);
         chk("t6 accepted", cand_valid0, 0);
         hash_valid0 = 1'b1;
         hash_data0 = hfun(11'(i));
         @(negedge clk);
         hash_valid0 = 1'b0;
      end
      chk("t6 state", state0, 3);
      chk("t6 found_word", found_word0, 1);
      chk("t6 attempts", attempts0, 2);
      chk("t6 mem reads", mem0_reads, 0);
      chk("t6 never dict", saw_dict0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
